// File: rtl/synth_rx_pkg.sv
// Shared definitions for the synthesizer receive-side analyzer.
// Holds the analyzer FSM state type, datapath widths and the offset-binary
// midscale value that represents a zero-amplitude sample.
package synth_rx_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CYC_W    = 24;
  localparam int TIMP_W   = 10;
  localparam int TPER_W   = 13;
  localparam int NIMP_W   = 5;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'd2048;

  typedef enum logic [1:0] {
    IDLE,
    IN_PULSE,
    IN_GAP
  } rx_state_e;

endpackage

// File: rtl/envelope_detector.sv
// Envelope detector: registers the incoming offset-binary sample, takes its
// distance from midscale and compares it against THRESHOLD.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   sample        : offset-binary sample, MIDSCALE = zero
//   sample_active : combinational activity flag of the registered sample
//   active        : sample_active delayed by one more register stage
module envelope_detector
  import synth_rx_pkg::*;
#(
  parameter int THRESHOLD = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sample_active,
  output logic                active
);

  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] abs_val;

  // The input register resets to midscale so that a freshly reset analyzer
  // does not see a full-scale (active) sample on its first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= MIDSCALE;
      active   <= 1'b0;
    end else begin
      sample_q <= sample;
      active   <= sample_active;
    end
  end

  // Sample 0 maps to 2048, which still fits in SAMPLE_W bits.
  always_comb begin
    abs_val       = (sample_q >= MIDSCALE) ? (sample_q - MIDSCALE) : (MIDSCALE - sample_q);
    sample_active = (abs_val > SAMPLE_W'(THRESHOLD));
  end

endmodule

// File: rtl/pulse_train_analyzer.sv
// Pulse train analyzer: recovers impulse width, start-to-start period and
// impulse count of a burst from the synthesizer's sample stream.
//   CLK, RESET     : clock, asynchronous active-low reset
//   ENABLE         : low aborts any measurement in progress
//   SAMPLE         : 12-bit offset-binary sample
//   ACTIVE         : registered envelope
//   IMP_VALID      : strobe with IMP_WIDTH_CYC / IMP_WIDTH_US
//   PER_VALID      : strobe with PER_CYC / PER_US
//   BURST_DONE     : strobe with NUM_OF_IMP
//   OVERFLOW       : sticky cycle-counter saturation flag
module pulse_train_analyzer
  import synth_rx_pkg::*;
#(
  parameter int CLK_PER_US  = 500,
  parameter int THRESHOLD   = 256,
  parameter int GAP_SAMPLES = 64,
  parameter int BURST_GAP   = 4096
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic [SAMPLE_W-1:0] SAMPLE,
  output logic                ACTIVE,
  output logic                IMP_VALID,
  output logic [CYC_W-1:0]    IMP_WIDTH_CYC,
  output logic [TIMP_W-1:0]   IMP_WIDTH_US,
  output logic                PER_VALID,
  output logic [CYC_W-1:0]    PER_CYC,
  output logic [TPER_W-1:0]   PER_US,
  output logic                BURST_DONE,
  output logic [NIMP_W-1:0]   NUM_OF_IMP,
  output logic                OVERFLOW
);

  localparam int PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int QUIET_W = $clog2(BURST_GAP + 1);

  localparam logic [CYC_W-1:0]   CYC_MAX   = '1;
  localparam logic [TPER_W-1:0]  US_MAX    = '1;
  localparam logic [TIMP_W-1:0]  TIMP_MAX  = '1;
  localparam logic [NIMP_W-1:0]  NIMP_MAX  = '1;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [PRE_W-1:0]   PRE_START = (CLK_PER_US > 1) ? PRE_W'(1) : '0;
  localparam logic [TPER_W-1:0]  US_START  = (CLK_PER_US > 1) ? '0 : TPER_W'(1);
  localparam logic [QUIET_W-1:0] GAP_END   = QUIET_W'(GAP_SAMPLES);
  localparam logic [QUIET_W-1:0] BURST_END = QUIET_W'(BURST_GAP);

  rx_state_e state, state_d;

  logic                sample_active;
  logic                cyc_sat;
  logic [CYC_W-1:0]    cyc_cnt, cyc_cnt_d, cyc_inc;
  logic [PRE_W-1:0]    pre_cnt, pre_cnt_d, pre_inc;
  logic [TPER_W-1:0]   us_cnt, us_cnt_d, us_inc;
  logic [QUIET_W-1:0]  quiet_cnt, quiet_cnt_d, quiet_inc;
  logic [NIMP_W-1:0]   imp_cnt, imp_cnt_d;
  logic [CYC_W-1:0]    last_width, last_width_d;
  logic [TPER_W-1:0]   last_us, last_us_d;

  logic                imp_valid_d, per_valid_d, burst_done_d, overflow_d;
  logic [CYC_W-1:0]    imp_width_cyc_d, per_cyc_d;
  logic [TIMP_W-1:0]   imp_width_us_d;
  logic [TPER_W-1:0]   per_us_d;
  logic [NIMP_W-1:0]   num_of_imp_d;

  envelope_detector #(
    .THRESHOLD (THRESHOLD)
  ) u_envelope (
    .clk           (CLK),
    .rst_n         (RESET),
    .sample        (SAMPLE),
    .sample_active (sample_active),
    .active        (ACTIVE)
  );

  // cyc_cnt holds (current sample index - S + 1); pre_cnt/us_cnt track the
  // same quantity split into whole microseconds plus remainder, so no divider
  // is needed. Everything freezes once the cycle counter saturates.
  always_comb begin
    cyc_sat   = (cyc_cnt == CYC_MAX);
    cyc_inc   = cyc_sat ? cyc_cnt : cyc_cnt + 1'b1;
    pre_inc   = pre_cnt;
    us_inc    = us_cnt;
    quiet_inc = quiet_cnt + 1'b1;
    if (!cyc_sat) begin
      if (pre_cnt == PRE_LAST) begin
        pre_inc = '0;
        if (us_cnt != US_MAX) us_inc = us_cnt + 1'b1;
      end else begin
        pre_inc = pre_cnt + 1'b1;
      end
    end
  end

  // The FSM acts on the registered sample (one edge before ACTIVE), so its
  // strobes line up with ACTIVE rather than lagging it by a cycle.
  always_comb begin
    state_d         = state;
    cyc_cnt_d       = cyc_cnt;
    pre_cnt_d       = pre_cnt;
    us_cnt_d        = us_cnt;
    quiet_cnt_d     = quiet_cnt;
    imp_cnt_d       = imp_cnt;
    last_width_d    = last_width;
    last_us_d       = last_us;
    imp_valid_d     = 1'b0;
    per_valid_d     = 1'b0;
    burst_done_d    = 1'b0;
    imp_width_cyc_d = IMP_WIDTH_CYC;
    imp_width_us_d  = IMP_WIDTH_US;
    per_cyc_d       = PER_CYC;
    per_us_d        = PER_US;
    num_of_imp_d    = NUM_OF_IMP;
    overflow_d      = OVERFLOW;

    if (!ENABLE) begin
      state_d      = IDLE;
      cyc_cnt_d    = '0;
      pre_cnt_d    = '0;
      us_cnt_d     = '0;
      quiet_cnt_d  = '0;
      imp_cnt_d    = '0;
      last_width_d = '0;
      last_us_d    = '0;
      overflow_d   = 1'b0;
    end else begin
      if (state != IDLE && cyc_sat) overflow_d = 1'b1;
      unique case (state)
        IDLE: begin
          if (sample_active) begin
            state_d      = IN_PULSE;
            cyc_cnt_d    = CYC_W'(1);
            pre_cnt_d    = PRE_START;
            us_cnt_d     = US_START;
            quiet_cnt_d  = '0;
            imp_cnt_d    = NIMP_W'(1);
            last_width_d = CYC_W'(1);
            last_us_d    = US_START;
          end
        end
        IN_PULSE: begin
          cyc_cnt_d = cyc_inc;
          pre_cnt_d = pre_inc;
          us_cnt_d  = us_inc;
          if (sample_active) begin
            quiet_cnt_d  = '0;
            last_width_d = cyc_inc;
            last_us_d    = us_inc;
          end else begin
            quiet_cnt_d = quiet_inc;
            if (quiet_inc == GAP_END) begin
              state_d         = IN_GAP;
              imp_valid_d     = 1'b1;
              imp_width_cyc_d = last_width;
              imp_width_us_d  = (last_us > TPER_W'(TIMP_MAX)) ? TIMP_MAX : last_us[TIMP_W-1:0];
            end
          end
        end
        IN_GAP: begin
          if (sample_active) begin
            // Before restarting, cyc_cnt still equals S2 - S.
            state_d      = IN_PULSE;
            per_valid_d  = 1'b1;
            per_cyc_d    = cyc_cnt;
            per_us_d     = us_cnt;
            cyc_cnt_d    = CYC_W'(1);
            pre_cnt_d    = PRE_START;
            us_cnt_d     = US_START;
            quiet_cnt_d  = '0;
            imp_cnt_d    = (imp_cnt == NIMP_MAX) ? imp_cnt : imp_cnt + 1'b1;
            last_width_d = CYC_W'(1);
            last_us_d    = US_START;
          end else begin
            cyc_cnt_d   = cyc_inc;
            pre_cnt_d   = pre_inc;
            us_cnt_d    = us_inc;
            quiet_cnt_d = quiet_inc;
            if (quiet_inc == BURST_END) begin
              state_d      = IDLE;
              burst_done_d = 1'b1;
              num_of_imp_d = imp_cnt;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_d;
  end

  // Counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cyc_cnt       <= '0;
      pre_cnt       <= '0;
      us_cnt        <= '0;
      quiet_cnt     <= '0;
      imp_cnt       <= '0;
      last_width    <= '0;
      last_us       <= '0;
      IMP_VALID     <= 1'b0;
      IMP_WIDTH_CYC <= '0;
      IMP_WIDTH_US  <= '0;
      PER_VALID     <= 1'b0;
      PER_CYC       <= '0;
      PER_US        <= '0;
      BURST_DONE    <= 1'b0;
      NUM_OF_IMP    <= '0;
      OVERFLOW      <= 1'b0;
    end else begin
      cyc_cnt       <= cyc_cnt_d;
      pre_cnt       <= pre_cnt_d;
      us_cnt        <= us_cnt_d;
      quiet_cnt     <= quiet_cnt_d;
      imp_cnt       <= imp_cnt_d;
      last_width    <= last_width_d;
      last_us       <= last_us_d;
      IMP_VALID     <= imp_valid_d;
      IMP_WIDTH_CYC <= imp_width_cyc_d;
      IMP_WIDTH_US  <= imp_width_us_d;
      PER_VALID     <= per_valid_d;
      PER_CYC       <= per_cyc_d;
      PER_US        <= per_us_d;
      BURST_DONE    <= burst_done_d;
      NUM_OF_IMP    <= num_of_imp_d;
      OVERFLOW      <= overflow_d;
    end
  end

endmodule

// File: doc/pulse_train_analyzer.md
Name: pulse_train_analyzer

Overview:
Receive-side counterpart of the digital synthesizer. Takes the synthesizer's 12-bit offset-binary sample stream and recovers the burst parameters the generator was programmed with: impulse duration, repetition period and number of impulses. The loopback/self-test path uses it to check generator output against the programmed T_IMPULSE / T_PERIOD / NUM_OF_IMP without an external scope.

Parameters:
CLK_PER_US, 500, clock cycles per microsecond; all US outputs are floor(cycles / CLK_PER_US).
THRESHOLD, 256, activity threshold on |SAMPLE - 2048|.
GAP_SAMPLES, 64, consecutive inactive samples that end an impulse (bridges carrier zero crossings).
BURST_GAP, 4096, consecutive inactive samples that end a burst; must be > GAP_SAMPLES.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-low reset.
ENABLE  in  1  analyzer enable; deassertion aborts measurement.
SAMPLE  in  12  synthesizer output sample, offset binary, 2048 = zero.
ACTIVE  out  1  registered envelope: |SAMPLE - 2048| > THRESHOLD.
IMP_VALID  out  1  one-cycle strobe: impulse measurement ready.
IMP_WIDTH_CYC  out  24  impulse width in cycles.
IMP_WIDTH_US  out  10  impulse width in us.
PER_VALID  out  1  one-cycle strobe: period measurement ready.
PER_CYC  out  24  start-to-start period in cycles.
PER_US  out  13  period in us.
BURST_DONE  out  1  one-cycle strobe: burst ended.
NUM_OF_IMP  out  5  impulses counted in the finished burst.
OVERFLOW  out  1  sticky: a cycle counter saturated; cleared by reset or ENABLE low.

Behaviour:
- Reset (RESET = 0, any time, asynchronous): all outputs 0, FSM in IDLE, all counters 0.
- Edge numbering: "edge k" means the rising edge that captures SAMPLE. ACTIVE is high from edge k+1 when the sample at edge k is active.
- Envelope: abs = |SAMPLE - 2048| (12-bit unsigned; SAMPLE = 0 gives 2048). A sample is active iff abs > THRESHOLD (strict).
- FSM states: IDLE, IN_PULSE, IN_GAP.
- IDLE -> IN_PULSE on the first active sample:
  - record start edge S;
  - impulse count = 1;
  - no period is reported for the first impulse.
- IN_PULSE:
  - each active sample resets the quiet counter and records last-active edge L;
  - after GAP_SAMPLES consecutive inactive samples, go to IN_GAP.
  - IMP_VALID is high for one cycle from edge L+GAP_SAMPLES+1, with IMP_WIDTH_CYC = L-S+1 and IMP_WIDTH_US = floor(IMP_WIDTH_CYC / CLK_PER_US).
- IN_GAP:
  - an active sample at edge S2 starts a new impulse: go to IN_PULSE and increment the impulse count (saturate at 31).
  - PER_VALID is high for one cycle from edge S2+1, with PER_CYC = S2-S and PER_US = floor(PER_CYC / CLK_PER_US); then S := S2.
  - If the inactive count since L reaches BURST_GAP, BURST_DONE is high for one cycle from edge L+BURST_GAP+1 with NUM_OF_IMP = count; return to IDLE.
- Data outputs hold their last value until the next corresponding strobe.
- Saturation: cycle counters saturate at 2^24-1 and set OVERFLOW. US outputs saturate at 1023 and 8191 respectively.
- ENABLE low: next edge returns to IDLE; no strobes issued for the aborted impulse or burst; data outputs hold.
- ENABLE high again: restarts cleanly at IDLE.
- An impulse still open when ENABLE drops is discarded.
- US conversion: running prescaler (0..CLK_PER_US-1) plus us counter, started at S; no divider.

Decomposition:
- Shared package synth_rx_pkg holds:
  - the state enum (IDLE / IN_PULSE / IN_GAP);
  - width constants SAMPLE_W = 12, CYC_W = 24, TIMP_W = 10, TPER_W = 13, NIMP_W = 5;
  - MIDSCALE = 2048.
- One sub-module, envelope_detector: input register, abs-from-midscale, threshold compare, registered ACTIVE.
- FSM and counters stay in the top module.

Test Plan (bench parameters: CLK_PER_US = 4, THRESHOLD = 256, GAP_SAMPLES = 8, BURST_GAP = 64):
- Single impulse: 40 samples alternating 3048/1048, then 200 samples of 2048 -> IMP_VALID once, IMP_WIDTH_CYC = 40, IMP_WIDTH_US = 10; BURST_DONE with NUM_OF_IMP = 1; no PER_VALID.
- Three impulses of 40 cycles at 100-cycle start spacing -> three IMP_VALID (width 40 / 10 us); two PER_VALID (PER_CYC = 100, PER_US = 25); BURST_DONE 65 cycles after the last active sample, NUM_OF_IMP = 3.
- Zero-crossing bridging: impulse containing 7-sample inactive holes -> one impulse, full width. 8-sample hole -> split into two impulses plus a PER_VALID.
- Threshold edge: abs = 256 never active; abs = 257 active; SAMPLE = 0 active.
- Abort: ENABLE low at cycle 20 of an impulse -> no IMP_VALID or BURST_DONE. Next impulse after re-enable is measured correctly with count = 1.
- Async reset asserted mid-impulse, between clock edges -> all outputs 0 immediately. 40 impulses of width 4, period 20 -> NUM_OF_IMP saturates at 31.
